// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
//   General-purpose register file for the multicycle CPU. It holds
//   2^ADDR_W registers of DATA_W bits and has three read ports and one
//   write port.
//   - Two datapath read ports (rs/rt) feed the A/B data registers.
//   - A debug read port feeds the board display logic.
//   - Register 0 always reads as zero. It has no storage and writes to it
//     are discarded.
//   - Reset is asynchronous and active-low. It clears every register at once
//     and holds all read outputs at zero while it is asserted.
//
// Parameters
//   DATA_W  register width in bits
//   ADDR_W  register address width; depth = 2**ADDR_W
//   BYPASS  1 = a read of the register being written this cycle returns
//               WriteData combinationally
//           0 = the read returns the stored (old) value
//
// Ports
//   CLK        in   system clock; writes occur on the rising edge
//   Reset      in   asynchronous active-low clear
//   RegWre     in   write enable, sampled at posedge CLK
//   ReadReg1   in   read port 1 address (rs)
//   ReadReg2   in   read port 2 address (rt)
//   WriteReg   in   write address
//   WriteData  in   write-back data
//   DebugReg   in   debug read address
//   ReadData1  out  contents of ReadReg1
//   ReadData2  out  contents of ReadReg2
//   DebugData  out  contents of DebugReg
// ----------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              RegWre,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] DebugReg,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] DebugData
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int N_RPORT = 3;

    // A write is only effective to a non-zero address. Gating with Reset here
    // also keeps the bypass path quiet while the file is held in reset.
    logic                           w_wr_en;
    logic [DEPTH-1:0][DATA_W-1:0]   w_regs;
    logic [N_RPORT-1:0][ADDR_W-1:0] w_raddr;
    logic [N_RPORT-1:0][DATA_W-1:0] w_rdata;

    assign w_wr_en = Reset && RegWre && (WriteReg != '0);

    // Register 0 has no storage.
    assign w_regs[0] = '0;

    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_reg
        logic [DATA_W-1:0] r_q;

        always_ff @(posedge CLK or negedge Reset) begin
            if (!Reset) begin
                r_q <= '0;
            end else if (w_wr_en && (WriteReg == ADDR_W'(gi))) begin
                r_q <= WriteData;
            end
        end

        assign w_regs[gi] = r_q;
    end

    assign w_raddr[0] = ReadReg1;
    assign w_raddr[1] = ReadReg2;
    assign w_raddr[2] = DebugReg;

    // Each read port is handled independently. The bypass compare needs no
    // extra check for address 0, because w_wr_en is already false for a
    // write to address 0. The Reset gate forces zero at the outputs even
    // while the asynchronous clear is still settling.
    for (genvar gp = 0; gp < N_RPORT; gp++) begin : g_rport
        always_comb begin
            w_rdata[gp] = w_regs[w_raddr[gp]];
            if ((BYPASS != 0) && w_wr_en && (w_raddr[gp] == WriteReg)) begin
                w_rdata[gp] = WriteData;
            end
            if (!Reset) begin
                w_rdata[gp] = '0;
            end
        end
    end

    assign ReadData1 = w_rdata[0];
    assign ReadData2 = w_rdata[1];
    assign DebugData = w_rdata[2];

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

    logic        CLK;
    logic        Reset;
    logic        RegWre;
    logic [4:0]  ReadReg1, ReadReg2, WriteReg, DebugReg;
    logic [31:0] WriteData;
    logic [31:0] nb_rd1, nb_rd2, nb_dbg;
    logic [31:0] by_rd1, by_rd2, by_dbg;

    int checks   = 0;
    int failures = 0;

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nb (
        .CLK(CLK), .Reset(Reset), .RegWre(RegWre),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .WriteReg(WriteReg),
        .WriteData(WriteData), .DebugReg(DebugReg),
        .ReadData1(nb_rd1), .ReadData2(nb_rd2), .DebugData(nb_dbg)
    );

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_by (
        .CLK(CLK), .Reset(Reset), .RegWre(RegWre),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .WriteReg(WriteReg),
        .WriteData(WriteData), .DebugReg(DebugReg),
        .ReadData1(by_rd1), .ReadData2(by_rd2), .DebugData(by_dbg)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change 2 ns after a rising edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        RegWre = 1'b1; WriteReg = a; WriteData = d;
        step();
        RegWre = 1'b0;
    endtask

    task automatic test_reset();
        ReadReg1 = 5'd5; ReadReg2 = 5'd31; DebugReg = 5'd1;
        #1;
        checks++; if (nb_rd1 !== 32'h0) begin failures++; $display("FAIL reset_rd1_nb got=%h exp=%h", nb_rd1, 32'h0); end
        checks++; if (by_rd2 !== 32'h0) begin failures++; $display("FAIL reset_rd2_by got=%h exp=%h", by_rd2, 32'h0); end
        checks++; if (nb_dbg !== 32'h0) begin failures++; $display("FAIL reset_dbg_nb got=%h exp=%h", nb_dbg, 32'h0); end
        @(negedge CLK);
        Reset = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        do_write(5'd5, 32'hDEADBEEF);
        ReadReg1 = 5'd5;
        #1;
        checks++; if (nb_rd1 !== 32'hDEADBEEF) begin failures++; $display("FAIL pre_reset_rd1_nb got=%h exp=%h", nb_rd1, 32'hDEADBEEF); end
        checks++; if (by_rd1 !== 32'hDEADBEEF) begin failures++; $display("FAIL pre_reset_rd1_by got=%h exp=%h", by_rd1, 32'hDEADBEEF); end
        Reset = 1'b0;
        #1;
        checks++; if (nb_rd1 !== 32'h0) begin failures++; $display("FAIL async_reset_rd1_nb got=%h exp=%h", nb_rd1, 32'h0); end
        checks++; if (by_rd1 !== 32'h0) begin failures++; $display("FAIL async_reset_rd1_by got=%h exp=%h", by_rd1, 32'h0); end
        Reset = 1'b1;
        #1;
        checks++; if (nb_rd1 !== 32'h0) begin failures++; $display("FAIL cleared_rd1_nb got=%h exp=%h", nb_rd1, 32'h0); end
        for (int i = 0; i < 32; i++) begin
            DebugReg = 5'(i);
            #1;
            checks++; if (nb_dbg !== 32'h0) begin failures++; $display("FAIL cleared_dbg_nb reg=%0d got=%h exp=%h", i, nb_dbg, 32'h0); end
            checks++; if (by_dbg !== 32'h0) begin failures++; $display("FAIL cleared_dbg_by reg=%0d got=%h exp=%h", i, by_dbg, 32'h0); end
        end
        step();
    endtask

    task automatic test_basic();
        do_write(5'd3, 32'h12345678);
        ReadReg1 = 5'd3; ReadReg2 = 5'd3;
        #1;
        checks++; if (nb_rd1 !== 32'h12345678) begin failures++; $display("FAIL basic_rd1_nb got=%h exp=%h", nb_rd1, 32'h12345678); end
        checks++; if (nb_rd2 !== 32'h12345678) begin failures++; $display("FAIL basic_rd2_nb got=%h exp=%h", nb_rd2, 32'h12345678); end
        checks++; if (by_rd1 !== 32'h12345678) begin failures++; $display("FAIL basic_rd1_by got=%h exp=%h", by_rd1, 32'h12345678); end
        ReadReg2 = 5'd4;
        #1;
        checks++; if (nb_rd2 !== 32'h0) begin failures++; $display("FAIL basic_addr_follow_nb got=%h exp=%h", nb_rd2, 32'h0); end
        step();
    endtask

    task automatic test_reg0();
        RegWre = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFFFFFF;
        ReadReg1 = 5'd0; DebugReg = 5'd0;
        #1;
        checks++; if (nb_rd1 !== 32'h0) begin failures++; $display("FAIL reg0_pre_nb got=%h exp=%h", nb_rd1, 32'h0); end
        checks++; if (by_rd1 !== 32'h0) begin failures++; $display("FAIL reg0_pre_by got=%h exp=%h", by_rd1, 32'h0); end
        checks++; if (by_dbg !== 32'h0) begin failures++; $display("FAIL reg0_pre_dbg_by got=%h exp=%h", by_dbg, 32'h0); end
        step();
        RegWre = 1'b0;
        #1;
        checks++; if (nb_rd1 !== 32'h0) begin failures++; $display("FAIL reg0_post_nb got=%h exp=%h", nb_rd1, 32'h0); end
        checks++; if (by_rd1 !== 32'h0) begin failures++; $display("FAIL reg0_post_by got=%h exp=%h", by_rd1, 32'h0); end
        step();
    endtask

    task automatic test_we_gating();
        do_write(5'd7, 32'hA5A5A5A5);
        RegWre = 1'b0; WriteReg = 5'd7; WriteData = 32'h0;
        step(); step(); step();
        ReadReg1 = 5'd7;
        #1;
        checks++; if (nb_rd1 !== 32'hA5A5A5A5) begin failures++; $display("FAIL we_gate_nb got=%h exp=%h", nb_rd1, 32'hA5A5A5A5); end
        checks++; if (by_rd1 !== 32'hA5A5A5A5) begin failures++; $display("FAIL we_gate_by got=%h exp=%h", by_rd1, 32'hA5A5A5A5); end
        step();
    endtask

    task automatic test_same_cycle();
        do_write(5'd9, 32'h11111111);
        RegWre = 1'b1; WriteReg = 5'd9; WriteData = 32'h22222222;
        ReadReg1 = 5'd9; ReadReg2 = 5'd9; DebugReg = 5'd9;
        #1;
        checks++; if (nb_rd2 !== 32'h11111111) begin failures++; $display("FAIL same_pre_rd2_nb got=%h exp=%h", nb_rd2, 32'h11111111); end
        checks++; if (by_rd2 !== 32'h22222222) begin failures++; $display("FAIL same_pre_rd2_by got=%h exp=%h", by_rd2, 32'h22222222); end
        checks++; if (by_rd1 !== 32'h22222222) begin failures++; $display("FAIL same_pre_rd1_by got=%h exp=%h", by_rd1, 32'h22222222); end
        checks++; if (by_dbg !== 32'h22222222) begin failures++; $display("FAIL same_pre_dbg_by got=%h exp=%h", by_dbg, 32'h22222222); end
        checks++; if (nb_dbg !== 32'h11111111) begin failures++; $display("FAIL same_pre_dbg_nb got=%h exp=%h", nb_dbg, 32'h11111111); end
        step();
        RegWre = 1'b0;
        #1;
        checks++; if (nb_rd2 !== 32'h22222222) begin failures++; $display("FAIL same_post_rd2_nb got=%h exp=%h", nb_rd2, 32'h22222222); end
        checks++; if (by_rd2 !== 32'h22222222) begin failures++; $display("FAIL same_post_rd2_by got=%h exp=%h", by_rd2, 32'h22222222); end
        step();
    endtask

    task automatic test_collision();
        do_write(5'd4, 32'h77777777);
        Reset = 1'b0;
        RegWre = 1'b1; WriteReg = 5'd4; WriteData = 32'h5; DebugReg = 5'd4;
        #1;
        checks++; if (by_dbg !== 32'h0) begin failures++; $display("FAIL coll_in_reset_dbg_by got=%h exp=%h", by_dbg, 32'h0); end
        step();
        Reset = 1'b1;
        #1;
        checks++; if (nb_dbg !== 32'h0) begin failures++; $display("FAIL coll_after_reset_nb got=%h exp=%h", nb_dbg, 32'h0); end
        checks++; if (by_dbg !== 32'h5) begin failures++; $display("FAIL coll_bypass_by got=%h exp=%h", by_dbg, 32'h5); end
        RegWre = 1'b0;
        #1;
        checks++; if (by_dbg !== 32'h0) begin failures++; $display("FAIL coll_after_reset_by got=%h exp=%h", by_dbg, 32'h0); end
        RegWre = 1'b1;
        step();
        RegWre = 1'b0;
        #1;
        checks++; if (nb_dbg !== 32'h5) begin failures++; $display("FAIL coll_next_edge_nb got=%h exp=%h", nb_dbg, 32'h5); end
        checks++; if (by_dbg !== 32'h5) begin failures++; $display("FAIL coll_next_edge_by got=%h exp=%h", by_dbg, 32'h5); end
        step();
    endtask

    task automatic test_back_to_back();
        RegWre = 1'b1;
        WriteReg = 5'd10; WriteData = 32'h0000000A; step();
        WriteReg = 5'd11; WriteData = 32'hB0B0B0B0; step();
        WriteReg = 5'd31; WriteData = 32'hC001D00D; step();
        WriteReg = 5'd10; WriteData = 32'h8000000F; step();
        RegWre = 1'b0;
        ReadReg1 = 5'd10; ReadReg2 = 5'd11; DebugReg = 5'd31;
        #1;
        checks++; if (nb_rd1 !== 32'h8000000F) begin failures++; $display("FAIL b2b_rd1_nb got=%h exp=%h", nb_rd1, 32'h8000000F); end
        checks++; if (nb_rd2 !== 32'hB0B0B0B0) begin failures++; $display("FAIL b2b_rd2_nb got=%h exp=%h", nb_rd2, 32'hB0B0B0B0); end
        checks++; if (nb_dbg !== 32'hC001D00D) begin failures++; $display("FAIL b2b_dbg_nb got=%h exp=%h", nb_dbg, 32'hC001D00D); end
        checks++; if (by_dbg !== 32'hC001D00D) begin failures++; $display("FAIL b2b_dbg_by got=%h exp=%h", by_dbg, 32'hC001D00D); end
        ReadReg1 = 5'd3; ReadReg2 = 5'd7; DebugReg = 5'd9;
        #1;
        checks++; if (nb_rd1 !== 32'h12345678) begin failures++; $display("FAIL retain_r3_nb got=%h exp=%h", nb_rd1, 32'h12345678); end
        checks++; if (by_rd2 !== 32'hA5A5A5A5) begin failures++; $display("FAIL retain_r7_by got=%h exp=%h", by_rd2, 32'hA5A5A5A5); end
        checks++; if (nb_dbg !== 32'h22222222) begin failures++; $display("FAIL retain_r9_nb got=%h exp=%h", nb_dbg, 32'h22222222); end
        step();
    endtask

    initial begin
        Reset = 1'b0; RegWre = 1'b0;
        ReadReg1 = '0; ReadReg2 = '0; WriteReg = '0; DebugReg = '0;
        WriteData = '0;
        test_reset();
        test_reset_mid();
        test_basic();
        test_reg0();
        test_we_gating();
        test_same_cycle();
        test_back_to_back();
        test_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32 x 32-bit general-purpose register file for the multicycle CPU.
- Sits directly upstream of the A/B data registers: ReadData1 is latched by ADR, ReadData2 by BDR at the next CLK edge.
- Write-back (ALU result or memory data, selected by the datapath) enters through the single write port.
- A third read-only debug port feeds the board display logic.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth is 2^ADDR_W.
- BYPASS, 0, 1 = a read of the register being written this cycle returns WriteData combinationally; 0 = returns the stored old value.

Ports:
- CLK  input  1  system clock; all writes on the rising edge.
- Reset  input  1  asynchronous, active-low; clears every register.
- RegWre  input  1  write enable, sampled at posedge CLK.
- ReadReg1  input  ADDR_W  read port 1 address (rs).
- ReadReg2  input  ADDR_W  read port 2 address (rt).
- WriteReg  input  ADDR_W  write address (rd/rt, chosen upstream).
- WriteData  input  DATA_W  write-back data.
- DebugReg  input  ADDR_W  debug read address.
- ReadData1  output  DATA_W  contents of ReadReg1.
- ReadData2  output  DATA_W  contents of ReadReg2.
- DebugData  output  DATA_W  contents of DebugReg.

Behaviour:
- Storage: 2^ADDR_W registers of DATA_W bits. Register 0 is hardwired to zero.
- Reset:
  - Reset low clears all registers to 0 immediately, with no clock required.
  - While Reset is low, all three read outputs are 0 and writes are ignored.
  - Reset deassertion is not synchronised here; the first write takes effect at the first posedge CLK with Reset high.
  - Reset asserted in the same cycle as a write: reset wins and the register stays 0.
- Read ports:
  - Purely combinational, zero latency.
  - Outputs follow address changes within the same cycle.
  - Address 0 always reads 0.
- Write port:
  - At posedge CLK, if Reset is high and RegWre = 1 and WriteReg != 0, then reg[WriteReg] <= WriteData.
  - Writes to address 0 are silently discarded.
  - RegWre = 0 leaves all registers unchanged.
  - One write per cycle maximum.
- Read/write of the same address in the same cycle:
  - BYPASS = 0: read outputs show the old value until the edge, then the new value after the edge.
  - BYPASS = 1: when RegWre = 1, WriteReg != 0 and the read address equals WriteReg, the output equals WriteData combinationally before the edge.
  - The bypass applies independently to ReadData1, ReadData2 and DebugData.
  - The bypass never applies to address 0.
- Consumer timing: the multicycle control asserts RegWre only in WB states. ADR/BDR capture ReadData1/2 at the end of the ID state, so with BYPASS = 0 no hazard exists.
- Width: WriteData is stored unmodified; there is no sign or zero extension inside the block.
- No X propagation: every register holds a defined value after the first Reset.

Test Plan:
- Reset and zero:
  - Write 0xDEADBEEF to reg 5, then pulse Reset low mid-cycle (between edges).
  - Required: ReadData1 (ReadReg1 = 5) drops to 0 immediately without a clock edge.
  - Required: all 32 registers read 0 via the debug port.
- Basic write/read:
  - RegWre = 1, WriteReg = 3, WriteData = 0x12345678, one edge; then ReadReg1 = 3, ReadReg2 = 3.
  - Required: both outputs are 0x12345678 in the same cycle the addresses are applied.
- Register 0 protection:
  - RegWre = 1, WriteReg = 0, WriteData = 0xFFFFFFFF, one edge.
  - Required: ReadData1 (ReadReg1 = 0) = 0 before and after the edge.
  - Required: with BYPASS = 1, still 0 before the edge.
- Write-enable gating:
  - reg 7 = 0xA5A5A5A5; then RegWre = 0, WriteReg = 7, WriteData = 0x0, three edges.
  - Required: reg 7 still reads 0xA5A5A5A5.
- Same-cycle read/write:
  - reg 9 = 0x11111111; RegWre = 1, WriteReg = 9, WriteData = 0x22222222, ReadReg2 = 9.
  - Required before the edge: BYPASS = 0 gives 0x11111111, BYPASS = 1 gives 0x22222222.
  - Required after the edge: both configurations give 0x22222222.
- Reset vs write collision:
  - Reset low across a posedge with RegWre = 1, WriteReg = 4, WriteData = 0x5.
  - Required: after Reset goes high, reg 4 reads 0.
  - Required: the next edge with the same inputs makes it read 0x5.
